// File: rtl/alu_sched_pkg.sv
// Shared definitions for the alu_sched scheduler: flag bit positions, ALU op
// encodings, requester IDs and small helpers.
package alu_sched_pkg;

  localparam int CIDX  = 0;
  localparam int VIDX  = 1;
  localparam int ZIDX  = 2;
  localparam int SIDX  = 3;
  localparam int PIDX  = 4;
  localparam int UIDX  = 5;
  localparam int N1IDX = 6;
  localparam int N2IDX = 7;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h04;
  localparam logic [5:0] OP_ADC = 6'h05;
  localparam logic [5:0] OP_SUB = 6'h06;
  localparam logic [5:0] OP_SBB = 6'h07;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_MON = 1'b1;

  // Width of the starvation-counter debug view exported on the interface.
  localparam int DBG_CW = 8;

  function automatic logic [1:0] port_mask(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Bus bundle between the scheduler, its two requesters, the shared ALU and
// the response consumer. slave = scheduler side, master = environment side.
interface alu_sched_if #(
  parameter int WIDTH  = 32,
  parameter int IWIDTH = 16
);
  import alu_sched_pkg::*;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; the source holds valid and payload stable until then, and
  // ready may depend combinationally on valid.
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [11:0]         req_op;
  logic [2*WIDTH-1:0]  req_bi;
  logic [2*WIDTH-1:0]  req_di;
  logic [2*IWIDTH-1:0] req_im;

  logic [5:0]          alu_op;
  logic [7:0]          alu_fi;
  logic [WIDTH-1:0]    alu_bi;
  logic [WIDTH-1:0]    alu_di;
  logic [IWIDTH-1:0]   alu_im;
  logic [WIDTH-1:0]    alu_res;
  logic [7:0]          alu_fo;
  logic                alu_wb_en;
  logic                alu_flag_en;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [WIDTH-1:0]    rsp_res;
  logic                rsp_wb_en;
  logic [7:0]          rsp_flags;

  logic                fw_en;
  logic [7:0]          fw_data;
  logic [7:0]          flags;
  logic [DBG_CW-1:0]   dbg_starve_cnt;

  modport slave (
    input  req_valid, req_op, req_bi, req_di, req_im,
    input  alu_res, alu_fo, alu_wb_en, alu_flag_en,
    input  rsp_ready, fw_en, fw_data,
    output req_ready, alu_op, alu_fi, alu_bi, alu_di, alu_im,
    output rsp_valid, rsp_id, rsp_res, rsp_wb_en, rsp_flags,
    output flags, dbg_starve_cnt
  );

  modport master (
    output req_valid, req_op, req_bi, req_di, req_im,
    output alu_res, alu_fo, alu_wb_en, alu_flag_en,
    output rsp_ready, fw_en, fw_data,
    input  req_ready, alu_op, alu_fi, alu_bi, alu_di, alu_im,
    input  rsp_valid, rsp_id, rsp_res, rsp_wb_en, rsp_flags,
    input  flags, dbg_starve_cnt
  );

endinterface

// File: rtl/alu_sched_arb.sv
// Two-port fixed-priority arbiter (port 0 wins) with a starvation counter that
// forces a port-1 grant after STARVE consecutive port-0 grants.
module alu_sched_arb
  import alu_sched_pkg::*;
#(
  parameter  int STARVE = 4,
  localparam int CW     = $clog2(STARVE + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    i_req_valid,
  input  logic          i_accept,
  output logic          o_sel,
  output logic [CW-1:0] o_starve_cnt
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE);

  logic [CW-1:0] r_starve_cnt;

  always_comb begin
    o_sel = ID_CPU;
    case (i_req_valid)
      2'b10:   o_sel = ID_MON;
      2'b11:   o_sel = (r_starve_cnt == LIMIT) ? ID_MON : ID_CPU;
      default: o_sel = ID_CPU;
    endcase
  end

  // Counts only port-0 wins that kept a waiting port 1 out; anything else resets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (i_accept) begin
      if ((o_sel == ID_CPU) && i_req_valid[1]) begin
        if (r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  assign o_starve_cnt = r_starve_cnt;

endmodule

// File: rtl/alu_sched.sv
// Shares one external combinational ALU between the CPU execute stage (port 0)
// and the debug monitor (port 1); owns the flag register and a registered response.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int IWIDTH = 16,
  parameter int STARVE = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  alu_sched_if.slave   bus
);

  localparam int CW = $clog2(STARVE + 1);

  logic             w_can_accept;
  logic             w_sel;
  logic             w_accept;
  logic [1:0]       w_req_ready;
  logic [7:0]       w_nf;
  logic [CW-1:0]    w_starve_cnt;

  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_res;
  logic             r_rsp_wb_en;
  logic [7:0]       r_rsp_flags;
  logic [7:0]       r_flags;

  // A direct flag write blocks acceptance so it can never race an ALU commit.
  assign w_can_accept = !bus.fw_en && (!r_rsp_valid || bus.rsp_ready);
  assign w_req_ready  = w_can_accept ? (bus.req_valid & port_mask(w_sel)) : 2'b00;
  assign w_accept     = |w_req_ready;

  alu_sched_arb #(.STARVE(STARVE)) u_arb (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_req_valid  (bus.req_valid),
    .i_accept     (w_accept),
    .o_sel        (w_sel),
    .o_starve_cnt (w_starve_cnt)
  );

  assign bus.alu_op = w_sel ? bus.req_op[11:6]             : bus.req_op[5:0];
  assign bus.alu_bi = w_sel ? bus.req_bi[2*WIDTH-1:WIDTH]  : bus.req_bi[WIDTH-1:0];
  assign bus.alu_di = w_sel ? bus.req_di[2*WIDTH-1:WIDTH]  : bus.req_di[WIDTH-1:0];
  assign bus.alu_im = w_sel ? bus.req_im[2*IWIDTH-1:IWIDTH] : bus.req_im[IWIDTH-1:0];
  assign bus.alu_fi = r_flags;

  assign w_nf = bus.alu_flag_en ? bus.alu_fo : r_flags;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= ID_CPU;
      r_rsp_res   <= '0;
      r_rsp_wb_en <= 1'b0;
      r_rsp_flags <= 8'h00;
      r_flags     <= 8'h00;
    end else begin
      if (bus.fw_en) begin
        r_flags <= bus.fw_data;
      end else if (w_accept) begin
        r_flags <= w_nf;
      end
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= w_sel;
        r_rsp_res   <= bus.alu_res;
        r_rsp_wb_en <= bus.alu_wb_en;
        r_rsp_flags <= w_nf;
      end else if (r_rsp_valid && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready      = w_req_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_id         = r_rsp_id;
  assign bus.rsp_res        = r_rsp_res;
  assign bus.rsp_wb_en      = r_rsp_wb_en;
  assign bus.rsp_flags      = r_rsp_flags;
  assign bus.flags          = r_flags;
  assign bus.dbg_starve_cnt = DBG_CW'(w_starve_cnt);

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Scheduler that shares one combinational alu2 datapath between two requesters: port 0 is the CPU execute stage, port 1 is the debug/monitor engine.
- Owns the architectural flag register, feeds it to the ALU as fi, and commits fo when flag_en is set.
- Drives a single registered response channel with valid/ready handshake.
- Arbitration is fixed priority to port 0, with a starvation limit that guarantees port 1 progress.

Parameters:
WIDTH, 32, datapath width.
IWIDTH, 16, immediate width.
STARVE, 4, maximum consecutive port-0 grants while port 1 is waiting.

Ports:
clk  in  1  clock; all state on rising edge.
reset_n  in  1  asynchronous reset, active-low.
req_valid  in  2  per-port request valid; bit i = port i.
req_ready  out  2  per-port accept; combinational.
req_op  in  12  port i op at [6i+5:6i].
req_bi  in  2*WIDTH  port i second operand register value.
req_di  in  2*WIDTH  port i destination/first operand value.
req_im  in  2*IWIDTH  port i immediate.
alu_op  out  6  to ALU.
alu_fi  out  8  to ALU; always equals flags.
alu_bi, alu_di  out  WIDTH  to ALU.
alu_im  out  IWIDTH  to ALU.
alu_res  in  WIDTH  from ALU.
alu_fo  in  8  from ALU.
alu_wb_en  in  1  from ALU.
alu_flag_en  in  1  from ALU.
rsp_valid  out  1  response held.
rsp_ready  in  1  consumer takes the response.
rsp_id  out  1  requester that owns the response.
rsp_res  out  WIDTH  registered ALU result.
rsp_wb_en  out  1  registered write-back enable.
rsp_flags  out  8  flags after this op.
fw_en  in  1  direct flag write (e.g. RETI/flag restore).
fw_data  in  8  value for the direct flag write.
flags  out  8  current flag register.

Behaviour:
- Reset (async, reset_n=0): rsp_valid=0, rsp_id=0, rsp_res=0, rsp_wb_en=0, rsp_flags=0, flags=8'h00, starve_cnt=0. Takes effect immediately, including mid-handshake. An in-flight response is discarded.
- can_accept = !fw_en & (!rsp_valid | rsp_ready).
- Selection:
  - Only one port valid: that port.
  - Both valid: port 1 if starve_cnt==STARVE, otherwise port 0.
  - Neither valid: sel=0.
- ALU inputs come combinationally from port sel. alu_fi=flags.
- req_ready[i] = can_accept & req_valid[i] & (sel==i). At most one bit is high.
- Accept edge (req_ready[sel]=1):
  - rsp_res<=alu_res, rsp_wb_en<=alu_wb_en, rsp_id<=sel, rsp_valid<=1.
  - nf = alu_flag_en ? alu_fo : flags; flags<=nf; rsp_flags<=nf.
- Back-to-back throughput is 1 op/cycle when rsp_ready=1. The next accept sees the updated flags (adc/sbb chains are correct).
- Drain: rsp_valid & rsp_ready & no accept -> rsp_valid<=0.
- Stall: rsp_valid & !rsp_ready -> all rsp_* outputs held stable, req_ready=0.
- starve_cnt:
  - Port 0 granted while req_valid[1]: increment, saturating at STARVE.
  - Port 1 granted, or req_valid[1]=0: clear to 0.
  - No accept: hold.
- fw_en=1: flags<=fw_data that edge; no accept that cycle. fw always wins.
- Ops with alu_wb_en=0 and alu_flag_en=0 (e.g. nop encodings) still produce a response.
- Requester rule: req_valid and payload must stay stable until req_ready. The block does not buffer requests.
- Latency: 1 cycle from accept edge to rsp_valid.

Decomposition:
- Shared defs include: flag index macros (CIDX, VIDX, ZIDX, SIDX, PIDX, UIDX, N1IDX, N2IDX), ALU op encodings (add 6'h04, adc 6'h05, ...), requester ID constants (ID_CPU=0, ID_MON=1).
- One natural sub-module, alu_sched_arb: computes sel and holds starve_cnt.
- alu2 is instantiated by the parent, not inside this block.

Test Plan:
- Port 0 add (op 6'h04), di=32'hFFFF_FFFF, bi=1, rsp_ready=1 -> next cycle rsp_res=0, rsp_id=0, rsp_wb_en=1, Z=1, C=1 in rsp_flags and flags.
- Back-to-back: above then port 0 adc (6'h05), di=0, bi=0 on the following cycle -> rsp_res=1, flag C=0, one result per cycle.
- STARVE=4, both ports valid continuously, rsp_ready=1 -> grant sequence 0,0,0,0,1,0,0,0,0,1.
- Backpressure: accept one op, hold rsp_ready=0 for 5 cycles -> req_ready=2'b00, rsp_* stable. On rsp_ready=1, the pending request is accepted that same cycle.
- fw_en=1, fw_data=8'h0F with req_valid=2'b01 -> req_ready=0 that cycle; flags=8'h0F next; request accepted the cycle after with alu_fi=8'h0F.
- reset_n pulled low while rsp_valid=1, rsp_ready=0 -> rsp_valid=0 and flags=0 immediately (no clock edge needed); starve_cnt=0 after release.
